// File: rtl/data_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_stream_pkg
// Description : Shared width helpers and beat type for the data stream FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package data_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int beat_width(input int data_width);
        return data_width + strb_width(data_width) + 1;
    endfunction

    // Beat layout for the default width; wider instances build the same layout locally.
    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0]             data;
        logic [strb_width(DEFAULT_DATA_WIDTH)-1:0] strb;
        logic                                      last;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/data_stream_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_stream_fifo_mem
// Description : DEPTH x WIDTH beat storage, one write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module data_stream_fifo_mem #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/data_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : data_stream_fifo
// Description : Valid/ready byte-strobed stream FIFO with level, almost-full
//               and optional in-place dropping of null beats.
// Revision    : 1.0 - initial release
// ============================================================================
module data_stream_fifo
    import data_stream_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int DEPTH              = 4,
    parameter int ALMOST_FULL_THRESH = DEPTH - 1,
    parameter bit DROP_NULL          = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic [strb_width(DATA_WIDTH)-1:0] s_strb,
    input  logic                              s_last,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [strb_width(DATA_WIDTH)-1:0] m_strb,
    output logic                              m_last,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [level_width(DEPTH)-1:0]     level,
    output logic                              almost_full
);

    localparam int SW = strb_width(DATA_WIDTH);
    localparam int LW = level_width(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = beat_width(DATA_WIDTH);

    localparam logic [LW-1:0] C_DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] C_AF_LVL    = LW'(ALMOST_FULL_THRESH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SW-1:0]         strb;
        logic                  last;
    } fifo_beat_t;

    if (DATA_WIDTH % 8 != 0) begin : g_chk_width
        $error("data_stream_fifo: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("data_stream_fifo: DEPTH must be a power of two >= 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_chk_thresh
        $error("data_stream_fifo: ALMOST_FULL_THRESH must be in 1..DEPTH");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          s_ready_q;
    logic          almost_full_q;
    logic          push, pop, dropped, store, empty;
    fifo_beat_t    wr_beat, rd_beat;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push    = s_valid & s_ready_q;
    assign pop     = ~empty & m_ready;
    // A null beat completes its handshake but never reaches storage.
    assign dropped = DROP_NULL & (s_strb == '0) & ~s_last;
    assign store   = push & ~dropped;

    assign wr_beat = '{data: s_data, strb: s_strb, last: s_last};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (store && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!store && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            s_ready_q     <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            s_ready_q     <= (level_d < C_DEPTH_LVL);
            almost_full_q <= (level_d >= C_AF_LVL);
        end
    end

    data_stream_fifo_mem #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_beat)
    );

    assign s_ready     = s_ready_q;
    assign m_valid     = ~empty;
    assign m_data      = rd_beat.data;
    assign m_strb      = rd_beat.strb;
    assign m_last      = rd_beat.last;
    assign level       = level_q;
    assign almost_full = almost_full_q;

endmodule
`default_nettype wire

// File: tb/tb_data_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_stream_fifo
// Description : Directed self-checking bench for data_stream_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_stream_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] s_data, m_data, s_data_b, m_data_b;
    logic [3:0]  s_strb, m_strb, s_strb_b, m_strb_b;
    logic        s_last, s_valid, s_ready, m_last, m_valid, m_ready, almost_full;
    logic        s_last_b, s_valid_b, s_ready_b, m_last_b, m_valid_b, m_ready_b, almost_full_b;
    logic [2:0]  level, level_b;

    int checks   = 0;
    int failures = 0;

    data_stream_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ALMOST_FULL_THRESH(3), .DROP_NULL(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_strb(s_strb), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_strb(m_strb), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .almost_full(almost_full)
    );

    data_stream_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ALMOST_FULL_THRESH(3), .DROP_NULL(1'b1)) u_dut_drop (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data_b), .s_strb(s_strb_b), .s_last(s_last_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_strb(m_strb_b), .m_last(m_last_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .level(level_b), .almost_full(almost_full_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_data = '0; s_strb = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_data_b = '0; s_strb_b = '0; s_last_b = 1'b0; s_valid_b = 1'b0; m_ready_b = 1'b0;
        #3;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_s_ready got=%b exp=1", s_ready); end
        checks++; if (s_ready_b !== 1'b1) begin failures++; $display("FAIL reset_release_s_ready_b got=%b exp=1", s_ready_b); end
    endtask

    task automatic test_fill_drain();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'h11 * (i + 1); s_strb = 4'hF; s_last = (i == 3);
            step();
            checks++; if (level !== 3'(i + 1)) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 3)) begin failures++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 3)); end
            checks++; if (s_ready !== (i + 1 < 4)) begin failures++; $display("FAIL fill_s_ready[%0d] got=%b exp=%b", i, s_ready, (i + 1 < 4)); end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'h11 * (i + 1) || m_last !== (i == 3)) begin
                failures++; $display("FAIL drain_beat[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, m_valid, m_data, m_last, 32'h11 * (i + 1), (i == 3));
            end
            step();
            checks++; if (level !== 3'(3 - i)) begin failures++; $display("FAIL drain_level[%0d] got=%0d exp=%0d", i, level, 3 - i); end
        end
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", m_valid); end
    endtask

    task automatic test_wrap();
        m_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (k == 0 || k == 11) begin
                if (m_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle[%0d] got=%b exp=0", k, m_valid); end
            end else if (m_valid !== 1'b1 || m_data !== 32'(k) || s_ready !== 1'b1) begin
                failures++; $display("FAIL wrap_beat[%0d] got v=%b d=%h rdy=%b exp v=1 d=%h rdy=1", k, m_valid, m_data, s_ready, 32'(k));
            end
            s_valid = (k < 10); s_data = 32'(k + 1); s_strb = 4'hF; s_last = 1'b0;
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'h51 + i; s_strb = 4'hF; s_last = 1'b0;
            step();
        end
        s_valid = 1'b0;
        checks++; if (level !== 3'd4 || s_ready !== 1'b0) begin failures++; $display("FAIL full_state got lvl=%0d rdy=%b exp lvl=4 rdy=0", level, s_ready); end
        s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b1;
        step();
        checks++; if (level !== 3'd3 || s_ready !== 1'b1) begin failures++; $display("FAIL full_pop got lvl=%0d rdy=%b exp lvl=3 rdy=1", level, s_ready); end
        checks++; if (m_data !== 32'h52 || almost_full !== 1'b1) begin failures++; $display("FAIL full_pop_head got d=%h af=%b exp d=52 af=1", m_data, almost_full); end
        m_ready = 1'b0;
        step();
        checks++; if (level !== 3'd4 || s_ready !== 1'b0) begin failures++; $display("FAIL full_refill got lvl=%0d rdy=%b exp lvl=4 rdy=0", level, s_ready); end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 32'h52 + i) begin failures++; $display("FAIL full_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, 32'h52 + i); end
            step();
        end
        m_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL full_drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_drop_null();
        m_ready_b = 1'b0;
        s_valid_b = 1'b1; s_data_b = 32'hAA; s_strb_b = 4'hF; s_last_b = 1'b0;
        step();
        checks++; if (level_b !== 3'd1) begin failures++; $display("FAIL drop_lvl_a got=%0d exp=1", level_b); end
        s_data_b = 32'hBB; s_strb_b = 4'h0; s_last_b = 1'b0;
        checks++; if (s_ready_b !== 1'b1) begin failures++; $display("FAIL drop_ready got=%b exp=1", s_ready_b); end
        step();
        checks++; if (level_b !== 3'd1) begin failures++; $display("FAIL drop_lvl_b got=%0d exp=1", level_b); end
        s_data_b = 32'hCC; s_strb_b = 4'h0; s_last_b = 1'b1;
        step();
        checks++; if (level_b !== 3'd2) begin failures++; $display("FAIL drop_lvl_c got=%0d exp=2", level_b); end
        s_valid_b = 1'b0; m_ready_b = 1'b1;
        checks++; if (m_valid_b !== 1'b1 || m_data_b !== 32'hAA || m_last_b !== 1'b0 || m_strb_b !== 4'hF) begin
            failures++; $display("FAIL drop_out0 got v=%b d=%h s=%h l=%b exp v=1 d=aa s=f l=0", m_valid_b, m_data_b, m_strb_b, m_last_b);
        end
        step();
        checks++; if (m_valid_b !== 1'b1 || m_data_b !== 32'hCC || m_last_b !== 1'b1 || m_strb_b !== 4'h0) begin
            failures++; $display("FAIL drop_out1 got v=%b d=%h s=%h l=%b exp v=1 d=cc s=0 l=1", m_valid_b, m_data_b, m_strb_b, m_last_b);
        end
        step();
        checks++; if (m_valid_b !== 1'b0 || level_b !== 3'd0) begin failures++; $display("FAIL drop_empty got v=%b lvl=%0d exp v=0 lvl=0", m_valid_b, level_b); end
        m_ready_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 32'h61 + i; s_strb = 4'hF; s_last = 1'b0;
            step();
        end
        s_valid = 1'b0;
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL rstmid_pre_level got=%0d exp=3", level); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || level !== 3'd0 || s_ready !== 1'b0 || almost_full !== 1'b0) begin
            failures++; $display("FAIL rstmid_async got v=%b lvl=%0d rdy=%b af=%b exp 0/0/0/0", m_valid, level, s_ready, almost_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || level !== 3'd0) begin
            failures++; $display("FAIL rstmid_release got rdy=%b v=%b lvl=%0d exp rdy=1 v=0 lvl=0", s_ready, m_valid, level);
        end
        step();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale got=%b exp=0", m_valid); end
    endtask

    task automatic test_stability();
        logic [36:0] sb[$];
        logic [36:0] held;
        logic        hold, push, pop;
        int          sent, recvd, cyc;
        sent = 0; recvd = 0; cyc = 0; hold = 1'b0; held = '0;
        s_valid = 1'b0;
        while ((sent < 200 || s_valid || sb.size() != 0) && cyc < 5000) begin
            if (hold) begin
                checks++;
                if ({m_valid, m_data, m_strb, m_last} !== {1'b1, held}) begin
                    failures++; $display("FAIL stable_hold cyc=%0d got v=%b beat=%h exp v=1 beat=%h", cyc, m_valid, {m_data, m_strb, m_last}, held);
                end
            end
            if (!s_valid && sent < 200 && $urandom_range(0, 9) < 8) begin
                s_valid = 1'b1; s_data = $urandom; s_strb = 4'($urandom); s_last = 1'($urandom);
                sent++;
            end
            m_ready = ($urandom_range(0, 9) < 3);
            push = s_valid && s_ready;
            pop  = m_valid && m_ready;
            if (pop) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL stable_spurious cyc=%0d got beat=%h exp none", cyc, {m_data, m_strb, m_last});
                end else begin
                    if ({m_data, m_strb, m_last} !== sb[0]) begin
                        failures++; $display("FAIL stable_order cyc=%0d got beat=%h exp beat=%h", cyc, {m_data, m_strb, m_last}, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                recvd++;
            end
            if (push) sb.push_back({s_data, s_strb, s_last});
            hold = m_valid && !m_ready;
            held = {m_data, m_strb, m_last};
            step();
            cyc++;
            if (push) s_valid = 1'b0;
        end
        s_valid = 1'b0; m_ready = 1'b0;
        checks++; if (cyc >= 5000) begin failures++; $display("FAIL stable_timeout got cycles=%0d exp <5000", cyc); end
        checks++; if (recvd != 200) begin failures++; $display("FAIL stable_count got=%0d exp=200", recvd); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_drop_null();
        test_reset_mid();
        test_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
